// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial LSB-first WIDTH-bit subtractor (a - b) with start/busy/done handshake
// Optional signed-overflow flag compiled in with `define SERIAL_SUB_OVF_EN.
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             bor_out
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d;
    logic [WIDTH-1:0] rb_q, rb_d;
    // Only the low WIDTH-1 result bits need storing; the final bit goes straight to diff.
    logic [WIDTH-2:0] sr_q, sr_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic             bor_q, bor_d;
    logic             s1, b1, d, b2, last;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic             ovf_q, ovf_d;
`endif

    always_comb begin
        s1   = ra_q[0] ^ rb_q[0];
        b1   = ~ra_q[0] & rb_q[0];
        d    = s1 ^ br_q;
        b2   = ~s1 & br_q;
        last = (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    always_comb begin
        ra_d   = ra_q;
        rb_d   = rb_q;
        sr_d   = sr_q;
        diff_d = diff_q;
        cnt_d  = cnt_q;
        br_d   = br_q;
        bor_d  = bor_q;
`ifdef SERIAL_SUB_OVF_EN
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        ovf_d    = ovf_q;
`endif
        if (state_q == S_IDLE && start) begin
            ra_d  = a;
            rb_d  = b;
            br_d  = 1'b0;
            cnt_d = '0;
`ifdef SERIAL_SUB_OVF_EN
            a_sign_d = a[WIDTH-1];
            b_sign_d = b[WIDTH-1];
`endif
        end else if (state_q == S_SHIFT) begin
            ra_d  = ra_q >> 1;
            rb_d  = rb_q >> 1;
            sr_d  = (WIDTH-1)'({d, sr_q} >> 1);
            br_d  = b1 | b2;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                diff_d = {d, sr_q};
                bor_d  = b1 | b2;
`ifdef SERIAL_SUB_OVF_EN
                ovf_d  = (a_sign_q != b_sign_q) & (d != a_sign_q);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra_q   <= '0;
            rb_q   <= '0;
            sr_q   <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            br_q   <= 1'b0;
            bor_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            ra_q   <= ra_d;
            rb_q   <= rb_d;
            sr_q   <= sr_d;
            diff_q <= diff_d;
            cnt_q  <= cnt_d;
            br_q   <= br_d;
            bor_q  <= bor_d;
`ifdef SERIAL_SUB_OVF_EN
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign diff    = diff_q;
    assign bor_out = bor_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf     = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - self-checking bench for serial_sub (WIDTH=8)
// Uses SERIAL_SUB_OVF_EN to decide whether the ovf port exists.
module tb_serial_sub;
    localparam int WIDTH = 8;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bor_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_sub #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf     (ovf),
`endif
        .bor_out (bor_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic signed_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        int sx;
        int sy;
        int r;
        sx = $signed(x);
        sy = $signed(y);
        r  = sx - sy;
        return (r > 127) || (r < -128);
    endfunction

    // Timeline model: phase counts edges since the accepting edge (0 = idle).
    int               m_phase = 0;
    logic [WIDTH-1:0] m_a     = '0;
    logic [WIDTH-1:0] m_b     = '0;
    logic [WIDTH-1:0] e_diff  = '0;
    logic             e_bor   = 1'b0;
    logic             e_ovf   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            e_diff  <= '0;
            e_bor   <= 1'b0;
            e_ovf   <= 1'b0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_a     <= a;
                m_b     <= b;
            end
        end else if (m_phase == WIDTH) begin
            m_phase <= WIDTH + 1;
            e_diff  <= m_a - m_b;
            e_bor   <= (m_a < m_b);
            e_ovf   <= signed_ovf(m_a, m_b);
        end else if (m_phase == WIDTH + 1) begin
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    always @(negedge clk) begin
        chk("model_busy", 32'(busy), 32'(m_phase != 0));
        chk("model_done", 32'(done), 32'(m_phase == WIDTH + 1));
        chk("model_diff", 32'(diff), 32'(e_diff));
        chk("model_bor", 32'(bor_out), 32'(e_bor));
`ifdef SERIAL_SUB_OVF_EN
        chk("model_ovf", 32'(ovf), 32'(e_ovf));
`endif
    end

    task automatic op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                      input logic [WIDTH-1:0] ed, input logic eb, input logic eo);
        int k;
        int nbusy;
        a     = av;
        b     = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        nbusy = busy ? 1 : 0;
        k     = 0;
        while (!done && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (busy) nbusy++;
        end
        chk("done_latency", 32'(k), 32'(WIDTH));
        chk("op_diff", 32'(diff), 32'(ed));
        chk("op_bor", 32'(bor_out), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        chk("op_ovf", 32'(ovf), 32'(eo));
`else
        if (eo !== 1'bx) begin end
`endif
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'(0));
        chk("busy_fall", 32'(busy), 32'(0));
        chk("busy_cycles", 32'(nbusy), 32'(WIDTH + 1));
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        bit seen_done;
        #12;
        chk("reset_busy", 32'(busy), 32'(0));
        chk("reset_done", 32'(done), 32'(0));
        chk("reset_diff", 32'(diff), 32'(0));
        chk("reset_bor", 32'(bor_out), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        op(8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
        op(8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
        op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        op(8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);
        op(8'h00, 8'hFF, 8'h01, 1'b1, 1'b0);

        // start held high; operands changed while busy must be ignored
        a = 8'h3C; b = 8'h0F; start = 1'b1;
        @(posedge clk); #1;
        a = 8'hAA; b = 8'h55;
        repeat (WIDTH) @(posedge clk);
        #1;
        chk("held1_done", 32'(done), 32'(1));
        chk("held1_diff", 32'(diff), 32'(8'h2D));
        chk("held1_bor", 32'(bor_out), 32'(0));
        @(posedge clk); #1;
        chk("held1_done_fall", 32'(done), 32'(0));
        chk("held1_diff_hold", 32'(diff), 32'(8'h2D));
        a = 8'h01; b = 8'h02;
        @(posedge clk); #1;
        a = 8'hC3; b = 8'h11;
        repeat (WIDTH) @(posedge clk);
        #1;
        chk("held2_done", 32'(done), 32'(1));
        chk("held2_diff", 32'(diff), 32'(8'hFF));
        chk("held2_bor", 32'(bor_out), 32'(1));
        @(posedge clk); #1;
        a = 8'h7F; b = 8'hFF;
        @(posedge clk); #1;
        start = 1'b0; a = 8'h00; b = 8'h00;
        repeat (WIDTH) @(posedge clk);
        #1;
        chk("held3_done", 32'(done), 32'(1));
        chk("held3_diff", 32'(diff), 32'(8'h80));
        chk("held3_bor", 32'(bor_out), 32'(1));
`ifdef SERIAL_SUB_OVF_EN
        chk("held3_ovf", 32'(ovf), 32'(1));
`endif
        @(posedge clk); #1;

        // asynchronous reset four edges into SHIFT
        a = 8'h5A; b = 8'h23; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        chk("abort_diff", 32'(diff), 32'(0));
        chk("abort_bor", 32'(bor_out), 32'(0));
`ifdef SERIAL_SUB_OVF_EN
        chk("abort_ovf", 32'(ovf), 32'(0));
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        chk("abort_no_done", 32'(seen_done), 32'(0));
        op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
# serial_sub

Bit-serial WIDTH-bit subtractor computing a − b LSB-first, one bit per clock, through a full-subtract cell made of two half-subtract cells and a registered borrow. It sits between the operand source and the result consumer, and trades WIDTH cycles of latency for a single-bit datapath. A start/busy/done handshake frames each operation. Results are held until the next operation completes.

## Interface
- WIDTH, 8, operand and result width in bits; legal range WIDTH ≥ 2.
- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high whenever state ≠ IDLE.
- done  output  1  one-cycle pulse; result registers valid from this cycle.
- diff  output  WIDTH  a − b modulo 2^WIDTH.
- bor_out  output  1  final borrow; 1 when a < b as unsigned values.
- ovf  output  1  signed overflow flag; present only with SERIAL_SUB_OVF_EN.

## Operation
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- **IDLE with start=1**
  - Load ra←a and rb←b.
  - Clear the borrow flop br←0 and the bit counter cnt←0.
  - Latch the sign bits a[WIDTH-1] and b[WIDTH-1].
  - Go to SHIFT.
- **IDLE with start=0:** hold all state.
- **SHIFT, one bit per cycle:**
  - Half-subtract cell 1 on (ra[0], rb[0]) gives s1 = ra[0]^rb[0] and b1 = ~ra[0]&rb[0].
  - Half-subtract cell 2 on (s1, br) gives d = s1^br and b2 = ~s1&br.
  - br←b1|b2.
  - d shifts into the MSB of the internal shift register sr (sr shifts right).
  - ra and rb shift right; cnt←cnt+1.
- **SHIFT exit:** on the cycle where cnt == WIDTH−1 the last bit is processed, and state goes to DONE. On that same edge:
  - diff←{d, sr[WIDTH-1:1]}.
  - bor_out←b1|b2.
  - ovf updates too (when compiled in).
- **DONE:** done=1 for exactly one cycle; then go to IDLE unconditionally.
- **Start filtering:** start is ignored in SHIFT and DONE. No queuing, and operands presented then are discarded.
- **Output hold:** diff, bor_out and ovf change only on entry to DONE and hold until the next entry to DONE.
- **Counter width:** cnt is $clog2(WIDTH) bits. It must not wrap before the exit compare.
- **Reset values:** busy=0, done=0, diff=0, bor_out=0, ovf=0. Internal ra, rb, sr, br and cnt are all 0.
- **Reset during SHIFT or DONE:** the operation is aborted immediately (asynchronously). No done pulse occurs, and prior results are cleared to 0.

## Timing
- Start is sampled at edge E. SHIFT runs over edges E+1..E+WIDTH.
- done and busy outputs:
  - done rises after edge E+WIDTH and falls after edge E+WIDTH+1.
  - busy rises after edge E and falls after edge E+WIDTH+1.
- Maximum throughput is one operation per WIDTH+2 cycles: a start held high is re-accepted on the first IDLE cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - ovf port and logic are present.
  - On entry to DONE, ovf←(a_sign ≠ b_sign) & (d ≠ a_sign), where d is the final result MSB.
- SERIAL_SUB_OVF_EN undefined:
  - The ovf port, the sign latches and the ovf logic are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x23, one-cycle start:
  - Result: diff=0x37, bor_out=0, ovf=0.
  - Handshake: done rises after edge E+8 for exactly one cycle; busy is high for 9 cycles.
- a=0x10, b=0x20:
  - diff=0xF0, bor_out=1, ovf=0.
- a=0x80, b=0x01:
  - diff=0x7F, bor_out=0, ovf=1 (with macro).
  - Without the macro the build has no ovf port and gives the same diff and bor_out.
- Edge operands:
  - a=0xFF, b=0xFF → diff=0x00, bor_out=0.
  - Then a=0x00, b=0xFF → diff=0x01, bor_out=1.
- start held high with operands changed during busy:
  - Only the operands at the accepting edges are used.
  - done pulses every 10 cycles.
  - diff holds between pulses.
- rst_n pulled low 4 cycles into SHIFT:
  - All outputs go to 0 immediately and no done pulse occurs.
  - After release, a=0x03, b=0x05 → diff=0xFE, bor_out=1.
